punc_mem_arbiter: RTL and testbench

- Shares the PUnC single-port LC3 memory between two requesters.
  - Port 0: the processor control/datapath (fetch, LD/ST/LDI/STI/LDR/STR accesses).
  - Port 1: a debug/loader port.
- Per-port request/acknowledge handshake; latches the winning request and sequences the memory's enable/write/read-latency timing.
- Fixed priority to the processor, with a starvation guard for the debug port.
- Sits between the control unit/datapath memory interface and the memory macro.

---
 rtl/punc_mem_arbiter_if.sv | 44 ++++
 rtl/punc_mem_arbiter.sv | 96 +++++++++
 tb/tb_punc_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/punc_mem_arbiter_if.sv
// punc_mem_arbiter_if: bundles the processor, debug and memory-macro signals of the PUnC memory arbiter.
// Ports (all logic):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> arbiter, cpu_ack/cpu_rdata <- arbiter
//   dbg_req/dbg_we/dbg_addr/dbg_wdata -> arbiter, dbg_ack/dbg_rdata <- arbiter
//   mem_en/mem_we/mem_addr/mem_wdata <- arbiter, mem_rdata -> arbiter
//   busy/owner <- arbiter (status)
// The arbiter takes the slave view; requesters plus the memory macro take the master view.
interface punc_mem_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        dbg_req;
   logic        dbg_we;
   logic [15:0] dbg_addr;
   logic [15:0] dbg_wdata;
   logic        dbg_ack;
   logic [15:0] dbg_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;
   logic        owner;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, owner
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, owner
   );
endinterface

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: shares the single-port PUnC memory between the processor (port 0) and a debug/loader port (port 1).
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset (0 = reset)
//   bus  - punc_mem_arbiter_if.slave: per-port req/we/addr/wdata in, ack/rdata out,
//          memory strobe/we/addr/wdata out, mem_rdata in, busy/owner status out
// Parameters:
//   RD_LAT   - cycles from the mem_en cycle until mem_rdata is valid (>=1)
//   MAX_WAIT - debug waiting cycles after which debug beats the processor (>=1)
module punc_mem_arbiter #(
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 8
) (
   input logic               clk,
   input logic               rst,
   punc_mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_WAIT + 1);
   localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   state_t      r_state;
   state_t      w_next;
   logic        r_owner;
   logic        r_we;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_cpu_rdata;
   logic [15:0] r_dbg_rdata;
   logic [SW-1:0] r_starve;
   logic [LW-1:0] r_lat;
   logic        w_any;
   logic        w_dbg_win;
   logic        w_grant;
   logic        w_last_wait;
   assign w_any       = bus.cpu_req | bus.dbg_req;
   // processor has priority unless debug has waited MAX_WAIT cycles
   assign w_dbg_win   = bus.dbg_req & (~bus.cpu_req | (r_starve >= SW'(MAX_WAIT)));
   assign w_grant     = (r_state == IDLE) & w_any;
   assign w_last_wait = (r_state == WAIT) & (r_lat == '0);
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? ACCESS : IDLE;
         ACCESS:  w_next = r_we ? RESP : WAIT;
         WAIT:    w_next = (r_lat == '0) ? RESP : WAIT;
         default: w_next = IDLE;
      endcase
   end
   // strobes are decoded from state so async reset drops them at once
   always_comb begin
      bus.mem_en    = r_state == ACCESS;
      bus.mem_we    = (r_state == ACCESS) & r_we;
      bus.mem_addr  = (r_state == IDLE) ? 16'h0 : r_addr;
      bus.mem_wdata = (r_state == IDLE) ? 16'h0 : r_wdata;
      bus.cpu_ack   = (r_state == RESP) & ~r_owner;
      bus.dbg_ack   = (r_state == RESP) & r_owner;
      bus.busy      = r_state != IDLE;
   end
   assign bus.owner     = r_owner;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dbg_rdata = r_dbg_rdata;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant) begin
         r_owner <= w_dbg_win;
         r_we    <= w_dbg_win ? bus.dbg_we    : bus.cpu_we;
         r_addr  <= w_dbg_win ? bus.dbg_addr  : bus.cpu_addr;
         r_wdata <= w_dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
      end
   // WAIT lasts RD_LAT cycles: load RD_LAT-1 in ACCESS, leave when it reaches zero
   always_ff @(posedge clk or negedge rst)
      if (!rst)                                r_lat <= '0;
      else if (r_state == ACCESS)              r_lat <= LW'(RD_LAT - 1);
      else if (r_state == WAIT && r_lat != '0) r_lat <= r_lat - LW'(1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else if (w_last_wait) begin
         if (r_owner) r_dbg_rdata <= bus.mem_rdata;
         else         r_cpu_rdata <= bus.mem_rdata;
      end
   // counts only cycles where the processor holds the memory, not IDLE arbitration cycles
   always_ff @(posedge clk or negedge rst)
      if (!rst)                                  r_starve <= '0;
      else if (!bus.dbg_req || (w_grant && w_dbg_win)) r_starve <= '0;
      else if (r_state != IDLE && !r_owner && r_starve < SW'(MAX_WAIT))
         r_starve <= r_starve + SW'(1);
endmodule

// File: tb/tb_punc_mem_arbiter.sv
// tb_punc_mem_arbiter: drives an RD_LAT=1 and an RD_LAT=3 arbiter against a transaction-level reference model.
module tb_punc_mem_arbiter;
   localparam int MAX_WAIT = 8;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic [1:0]  rst_n, cpu_req, cpu_we, dbg_req, dbg_we;
   logic [15:0] cpu_addr[2], cpu_wdata[2], dbg_addr[2], dbg_wdata[2];
   logic [1:0]  cpu_ack, dbg_ack, mem_en, mem_we, busy, owner;
   logic [15:0] cpu_rdata[2], dbg_rdata[2], mem_addr[2], mem_wdata[2];
   int checks = 0;
   int errors = 0;
   logic [15:0] ref_mem[int];
   logic [15:0] exp_crd[2], exp_drd[2];
   for (genvar g = 0; g < 2; g++) begin : gen
      localparam int LAT = g == 0 ? 1 : 3;
      punc_mem_arbiter_if bus ();
      logic [15:0] mem[65536];
      logic [15:0] pipe[3];
      assign bus.cpu_req   = cpu_req[g];
      assign bus.cpu_we    = cpu_we[g];
      assign bus.cpu_addr  = cpu_addr[g];
      assign bus.cpu_wdata = cpu_wdata[g];
      assign bus.dbg_req   = dbg_req[g];
      assign bus.dbg_we    = dbg_we[g];
      assign bus.dbg_addr  = dbg_addr[g];
      assign bus.dbg_wdata = dbg_wdata[g];
      assign bus.mem_rdata = pipe[LAT-1];
      assign cpu_ack[g]    = bus.cpu_ack;
      assign dbg_ack[g]    = bus.dbg_ack;
      assign cpu_rdata[g]  = bus.cpu_rdata;
      assign dbg_rdata[g]  = bus.dbg_rdata;
      assign mem_en[g]     = bus.mem_en;
      assign mem_we[g]     = bus.mem_we;
      assign mem_addr[g]   = bus.mem_addr;
      assign mem_wdata[g]  = bus.mem_wdata;
      assign busy[g]       = bus.busy;
      assign owner[g]      = bus.owner;
      // memory macro: read data of a strobe cycle appears LAT cycles later
      always @(posedge clk) begin
         if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         pipe[0] <= mem[bus.mem_addr];
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      punc_mem_arbiter #(.RD_LAT(LAT), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst_n[g]), .bus(bus));
   end
   function automatic logic [15:0] ref_rd(input int d, input logic [15:0] a);
      return ref_mem.exists(d * 65536 + int'(a)) ? ref_mem[d * 65536 + int'(a)] : 16'h0;
   endfunction
   // one arbitration round started in IDLE cycle 0; expectations follow the latency rules
   task automatic do_txn(input int d, input bit ce, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                         input bit de, input bit dw, input logic [15:0] da, input logic [15:0] dd, input string nm);
      int l = d == 0 ? 1 : 3;
      int c_ack = -1, d_en = -1, d_ack = -1, last;
      if (ce) begin
         c_ack = cw ? 2 : 2 + l;
         if (cw) ref_mem[d * 65536 + int'(ca)] = cd;
         else exp_crd[d] = ref_rd(d, ca);
      end
      if (de) begin
         d_en  = ce ? c_ack + 2 : 1;
         d_ack = d_en + (dw ? 1 : 1 + l);
         if (dw) ref_mem[d * 65536 + int'(da)] = dd;
         else exp_drd[d] = ref_rd(d, da);
      end
      last = de ? d_ack : c_ack;
      cpu_req[d] = ce; cpu_we[d] = cw; cpu_addr[d] = ca; cpu_wdata[d] = cd;
      dbg_req[d] = de; dbg_we[d] = dw; dbg_addr[d] = da; dbg_wdata[d] = dd;
      for (int k = 0; k <= last + 1; k++) begin
         bit e_ca, e_da, e_en, e_dbg, e_busy;
         @(negedge clk);
         e_ca   = ce && k == c_ack;
         e_da   = de && k == d_ack;
         e_dbg  = de && k == d_en;
         e_en   = (ce && k == 1) || e_dbg;
         e_busy = k >= 1 && k <= last && !(ce && de && k == c_ack + 1);
         checks++; if (cpu_ack[d] !== e_ca) begin errors++; $display("FAIL %s d%0d k%0d cpu_ack got %0b exp %0b", nm, d, k, cpu_ack[d], e_ca); end
         checks++; if (dbg_ack[d] !== e_da) begin errors++; $display("FAIL %s d%0d k%0d dbg_ack got %0b exp %0b", nm, d, k, dbg_ack[d], e_da); end
         checks++; if (mem_en[d] !== e_en) begin errors++; $display("FAIL %s d%0d k%0d mem_en got %0b exp %0b", nm, d, k, mem_en[d], e_en); end
         checks++; if (busy[d] !== e_busy) begin errors++; $display("FAIL %s d%0d k%0d busy got %0b exp %0b", nm, d, k, busy[d], e_busy); end
         if (e_en) begin
            checks++; if (owner[d] !== e_dbg) begin errors++; $display("FAIL %s d%0d k%0d owner got %0b exp %0b", nm, d, k, owner[d], e_dbg); end
            checks++; if (mem_addr[d] !== (e_dbg ? da : ca)) begin errors++; $display("FAIL %s d%0d k%0d mem_addr got %h exp %h", nm, d, k, mem_addr[d], e_dbg ? da : ca); end
            checks++; if (mem_we[d] !== (e_dbg ? dw : cw)) begin errors++; $display("FAIL %s d%0d k%0d mem_we got %0b exp %0b", nm, d, k, mem_we[d], e_dbg ? dw : cw); end
            if (e_dbg ? dw : cw) begin
               checks++; if (mem_wdata[d] !== (e_dbg ? dd : cd)) begin errors++; $display("FAIL %s d%0d k%0d mem_wdata got %h exp %h", nm, d, k, mem_wdata[d], e_dbg ? dd : cd); end
            end
         end else begin
            checks++; if (mem_we[d] !== 1'b0) begin errors++; $display("FAIL %s d%0d k%0d mem_we got %0b exp 0", nm, d, k, mem_we[d]); end
         end
         if (!e_busy) begin
            checks++; if ({mem_addr[d], mem_wdata[d]} !== 32'h0) begin errors++; $display("FAIL %s d%0d k%0d idle mem_addr/wdata got %h/%h exp 0", nm, d, k, mem_addr[d], mem_wdata[d]); end
         end
         @(posedge clk); #1;
         if (e_ca) cpu_req[d] = 1'b0;
         if (e_da) dbg_req[d] = 1'b0;
      end
      checks++; if (cpu_rdata[d] !== exp_crd[d]) begin errors++; $display("FAIL %s d%0d cpu_rdata got %h exp %h", nm, d, cpu_rdata[d], exp_crd[d]); end
      checks++; if (dbg_rdata[d] !== exp_drd[d]) begin errors++; $display("FAIL %s d%0d dbg_rdata got %h exp %h", nm, d, dbg_rdata[d], exp_drd[d]); end
   endtask
   task automatic test_reset();
      rst_n = 2'b00; cpu_req = 2'b11; dbg_req = 2'b11; cpu_we = 2'b00; dbg_we = 2'b11;
      for (int d = 0; d < 2; d++) begin
         cpu_addr[d] = 16'h1111; cpu_wdata[d] = 16'h2222; dbg_addr[d] = 16'h3333; dbg_wdata[d] = 16'h4444;
         exp_crd[d] = 16'h0; exp_drd[d] = 16'h0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy[d], owner[d], cpu_ack[d], dbg_ack[d], mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], cpu_rdata[d], dbg_rdata[d]} !== 70'h0) begin
            errors++; $display("FAIL reset d%0d outputs got busy=%b owner=%b acks=%b%b en=%b we=%b addr=%h wd=%h crd=%h drd=%h exp all 0", d, busy[d], owner[d],
               cpu_ack[d], dbg_ack[d], mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], cpu_rdata[d], dbg_rdata[d]);
         end
      end
      @(posedge clk); #1;
      cpu_req = 2'b00; dbg_req = 2'b00; rst_n = 2'b11;
   endtask
   task automatic test_cpu_read();
      do_txn(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h3000, 16'h1234, "preload_3000");
      exp_drd[0] = 16'h0;
      do_txn(0, 1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0, "cpu_read");
   endtask
   task automatic test_dbg_write();
      do_txn(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h4000, 16'hBEEF, "dbg_write");
      checks++; if (owner[0] !== 1'b1) begin errors++; $display("FAIL dbg_write owner got %0b exp 1", owner[0]); end
   endtask
   task automatic test_simultaneous();
      do_txn(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'hA5A5, "preload_0010");
      do_txn(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'h5A5A, "preload_0020");
      do_txn(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, "simultaneous");
   endtask
   task automatic test_lat3_read();
      do_txn(1, 0, 0, 16'h0, 16'h0, 1, 1, 16'hFFFF, 16'h8001, "preload_ffff");
      do_txn(1, 1, 0, 16'hFFFF, 16'h0, 0, 0, 16'h0, 16'h0, "lat3_read");
   endtask
   task automatic test_reset_mid_read();
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 16'hFFFF;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_en[1] !== 1'b1) begin errors++; $display("FAIL rst_mid access mem_en got %0b exp 1", mem_en[1]); end
      @(negedge clk);
      #1 rst_n[1] = 1'b0;
      #1;
      checks++;
      if ({mem_en[1], busy[1], cpu_ack[1], dbg_ack[1], owner[1], mem_addr[1], cpu_rdata[1], dbg_rdata[1]} !== 53'h0) begin
         errors++; $display("FAIL rst_mid outputs got en=%b busy=%b acks=%b%b owner=%b addr=%h crd=%h drd=%h exp all 0", mem_en[1], busy[1],
            cpu_ack[1], dbg_ack[1], owner[1], mem_addr[1], cpu_rdata[1], dbg_rdata[1]);
      end
      cpu_req[1] = 1'b0;
      exp_crd[1] = 16'h0; exp_drd[1] = 16'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if ({cpu_ack[1], busy[1]} !== 2'b00) begin errors++; $display("FAIL rst_mid hold k%0d ack/busy got %b%b exp 00", k, cpu_ack[1], busy[1]); end
      end
      @(posedge clk); #1;
      rst_n[1] = 1'b1;
      do_txn(1, 1, 0, 16'hFFFF, 16'h0, 0, 0, 16'h0, 16'h0, "rst_mid_reissue");
   endtask
   // processor writes back to back; each write gives the waiting debug port two counted cycles
   task automatic test_starvation(input int d);
      int l = d == 0 ? 1 : 3;
      int g = 3 * ((MAX_WAIT + 1) / 2);
      int ka = g + 2 + l;
      logic [15:0] wd = 16'($urandom);
      do_txn(d, 0, 0, 16'h0, 16'h0, 1, 1, 16'h6000, 16'($urandom), "preload_6000");
      ref_mem[d * 65536 + 16'h5000] = wd;
      exp_drd[d] = ref_rd(d, 16'h6000);
      cpu_req[d] = 1'b1; cpu_we[d] = 1'b1; cpu_addr[d] = 16'h5000; cpu_wdata[d] = wd;
      dbg_req[d] = 1'b1; dbg_we[d] = 1'b0; dbg_addr[d] = 16'h6000;
      for (int k = 0; k <= ka + 2; k++) begin
         bit e_en, e_ca, e_da, e_own;
         @(negedge clk);
         e_en  = (k < g && k % 3 == 1) || k == g + 1 || k == ka + 2;
         e_own = k == g + 1;
         e_ca  = k < g && k % 3 == 2;
         e_da  = k == ka;
         checks++; if (mem_en[d] !== e_en) begin errors++; $display("FAIL starve d%0d k%0d mem_en got %0b exp %0b", d, k, mem_en[d], e_en); end
         checks++; if (cpu_ack[d] !== e_ca) begin errors++; $display("FAIL starve d%0d k%0d cpu_ack got %0b exp %0b", d, k, cpu_ack[d], e_ca); end
         checks++; if (dbg_ack[d] !== e_da) begin errors++; $display("FAIL starve d%0d k%0d dbg_ack got %0b exp %0b", d, k, dbg_ack[d], e_da); end
         if (e_en) begin
            checks++; if (owner[d] !== e_own) begin errors++; $display("FAIL starve d%0d k%0d owner got %0b exp %0b", d, k, owner[d], e_own); end
         end
         @(posedge clk); #1;
      end
      cpu_req[d] = 1'b0; dbg_req[d] = 1'b0;
      for (int n = 0; n < 20 && busy[d]; n++) begin @(posedge clk); #1; end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL starve d%0d drain busy got %0b exp 0", d, busy[d]); end
      checks++; if (dbg_rdata[d] !== exp_drd[d]) begin errors++; $display("FAIL starve d%0d dbg_rdata got %h exp %h", d, dbg_rdata[d], exp_drd[d]); end
      checks++; if (cpu_rdata[d] !== exp_crd[d]) begin errors++; $display("FAIL starve d%0d cpu_rdata got %h exp %h", d, cpu_rdata[d], exp_crd[d]); end
   endtask
   task automatic test_random(input int d);
      logic [15:0] pool[4];
      for (int i = 0; i < 4; i++) begin
         pool[i] = {4'h7, 12'($urandom)};
         do_txn(d, 0, 0, 16'h0, 16'h0, 1, 1, pool[i], 16'($urandom), "rnd_preload");
      end
      for (int r = 0; r < 30; r++) begin
         bit ce = 1'($urandom_range(0, 1));
         bit de = ce ? 1'($urandom_range(0, 1)) : 1'b1;
         do_txn(d, ce, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], 16'($urandom),
                de, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], 16'($urandom), "random");
      end
   endtask
   initial begin
      test_reset();
      test_cpu_read();
      test_dbg_write();
      test_simultaneous();
      test_lat3_read();
      test_reset_mid_read();
      test_starvation(0);
      test_starvation(1);
      test_random(0);
      test_random(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
